// File: rtl/fde_controller.sv
// rtl/fde_controller.sv - fetch/decode/execute sequencing controller for the FDE CPU
// Optional single-step mode (i_step input, PAUSE state) is enabled by FDE_CTRL_SINGLE_STEP_EN.
module fde_controller #(
  parameter int PC_W          = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
`ifdef FDE_CTRL_SINGLE_STEP_EN
  input  logic            i_step,
`endif
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [15:0]     i_imem_data,
  output logic [3:0]      o_rf_rd_add1,
  output logic [3:0]      o_rf_rd_add2,
  output logic [3:0]      o_alu_opcode,
  output logic [3:0]      o_alu_destadd,
  output logic            o_wb_en,
  output logic [3:0]      o_wb_add,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_error,
  output logic [15:0]     o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
`ifdef FDE_CTRL_SINGLE_STEP_EN
    , S_PAUSE = 3'd6
`endif
  } state_t;

`ifdef FDE_CTRL_SINGLE_STEP_EN
  localparam state_t S_RETIRE = S_PAUSE;
`else
  localparam state_t S_RETIRE = S_FETCH;
`endif

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [7:0] TIMEOUT = 8'(FETCH_TIMEOUT);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [7:0]      wait_cnt;
  logic [15:0]     instr_count;
  logic            error;
  logic [3:0]      ir_op;
  logic            ir_is_alu;
  logic            ir_live;

  assign ir_op     = ir[15:12];
  assign ir_is_alu = (ir_op == 4'b0001) || (ir_op == 4'b0010) ||
                     (ir_op == 4'b0100) || (ir_op == 4'b1000);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: begin
        if (i_start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A late ack on the timeout cycle still wins over the error halt.
        if (i_imem_ack)                state_nxt = S_DECODE;
        else if (wait_cnt == TIMEOUT)  state_nxt = S_HALT;
      end
      S_DECODE: begin
        if (ir_op == OP_HALT) state_nxt = S_HALT;
        else if (ir_is_alu)   state_nxt = S_EXEC;
        else                  state_nxt = S_RETIRE;
      end
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_RETIRE;
`ifdef FDE_CTRL_SINGLE_STEP_EN
      S_PAUSE: begin
        if (i_step) state_nxt = S_FETCH;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc          <= '0;
      ir          <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            pc          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            error       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            ir       <= i_imem_data;
            pc       <= pc + PC_W'(1);
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT) begin
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if ((ir_op != OP_HALT) && !ir_is_alu) instr_count <= instr_count + 16'd1;
        end
        S_WB: instr_count <= instr_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign ir_live = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);

  assign o_imem_req    = (state == S_FETCH);
  assign o_imem_addr   = pc;
  assign o_rf_rd_add1  = ir_live ? ir[7:4] : 4'h0;
  assign o_rf_rd_add2  = ir_live ? ir[3:0] : 4'h0;
  assign o_alu_opcode  = (state == S_EXEC) ? ir[15:12] : 4'h0;
  assign o_alu_destadd = (state == S_EXEC) ? ir[11:8] : 4'h0;
  assign o_wb_en       = (state == S_WB);
  assign o_wb_add      = (state == S_WB) ? ir[11:8] : 4'h0;
  assign o_busy        = (state != S_IDLE) && (state != S_HALT);
  assign o_halted      = (state == S_HALT);
  assign o_error       = error;
  assign o_instr_count = instr_count;

endmodule

// File: tb/tb_fde_controller.sv
// tb/tb_fde_controller.sv - scoreboard bench for fde_controller against an instruction-level model
// Honours FDE_CTRL_SINGLE_STEP_EN by holding i_step high (one PAUSE cycle per retire).
`timescale 1ns/1ps
module tb_fde_controller;
  localparam int PC_W          = 2;
  localparam int FETCH_TIMEOUT = 15;
  localparam int NEVER         = 255;
`ifdef FDE_CTRL_SINGLE_STEP_EN
  localparam int PAUSE_CYC = 1;
`else
  localparam int PAUSE_CYC = 0;
`endif

  logic            clk = 1'b0;
  logic            i_reset;
  logic            i_start;
  logic            i_step;
  logic            o_imem_req;
  logic [PC_W-1:0] o_imem_addr;
  logic            i_imem_ack;
  logic [15:0]     i_imem_data;
  logic [3:0]      o_rf_rd_add1, o_rf_rd_add2, o_alu_opcode, o_alu_destadd, o_wb_add;
  logic            o_wb_en, o_busy, o_halted, o_error;
  logic [15:0]     o_instr_count;

  fde_controller #(.PC_W(PC_W), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_start(i_start),
`ifdef FDE_CTRL_SINGLE_STEP_EN
    .i_step(i_step),
`endif
    .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack),
    .i_imem_data(i_imem_data),
    .o_rf_rd_add1(o_rf_rd_add1),
    .o_rf_rd_add2(o_rf_rd_add2),
    .o_alu_opcode(o_alu_opcode),
    .o_alu_destadd(o_alu_destadd),
    .o_wb_en(o_wb_en),
    .o_wb_add(o_wb_add),
    .o_busy(o_busy),
    .o_halted(o_halted),
    .o_error(o_error),
    .o_instr_count(o_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct { int delay; logic [15:0] word; } fetch_t;
  typedef struct { int cyc; int a; int b; int c; int d; } ev_t;

  fetch_t prog[$];
  fetch_t resp_q[$];
  ev_t    addr_q[$], exec_q[$], wb_q[$], halt_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int start_cyc  = 0;
  bit mon_en     = 1'b0;
  bit late_ack   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endtask

  task automatic add(int delay, logic [15:0] w);
    fetch_t f;
    f.delay = delay;
    f.word  = w;
    prog.push_back(f);
  endtask

  function automatic bit is_alu(logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (op == 4'd4) || (op == 4'd8);
  endfunction

  // Instruction-level model: walks the fetch list and predicts every visible event and its cycle.
  task automatic build_expect();
    int t = 1;
    int pc = 0;
    int count = 0;
    foreach (prog[i]) begin
      logic [15:0] w;
      logic [3:0]  op;
      w  = prog[i].word;
      op = w[15:12];
      addr_q.push_back('{t, pc, 0, 0, 0});
      if (prog[i].delay > FETCH_TIMEOUT) begin
        halt_q.push_back('{t + FETCH_TIMEOUT + 1, count, 1, 0, 0});
        return;
      end
      t  = t + prog[i].delay + 1;
      pc = (pc + 1) % (1 << PC_W);
      if (op == 4'hF) begin
        halt_q.push_back('{t + 1, count, 0, 0, 0});
        return;
      end
      if (is_alu(op)) begin
        exec_q.push_back('{t + 1, int'(op), int'(w[11:8]), int'(w[7:4]), int'(w[3:0])});
        wb_q.push_back('{t + 2, int'(w[11:8]), int'(w[7:4]), int'(w[3:0]), 0});
        t = t + 3;
      end else begin
        t = t + 1;
      end
      count = (count + 1) % 65536;
      t = t + PAUSE_CYC;
    end
  endtask

  task automatic flush();
    addr_q.delete(); exec_q.delete(); wb_q.delete(); halt_q.delete(); resp_q.delete();
  endtask

  // Instruction memory responder: per-fetch delay and word come from resp_q; stray acks outside FETCH.
  initial begin : responder
    bit          prev_req = 1'b0;
    int          wait_left = NEVER;
    logic [15:0] word = 16'h0;
    fetch_t      f;
    i_imem_ack  = 1'b0;
    i_imem_data = 16'h0;
    forever begin
      @(negedge clk);
      i_imem_ack = 1'b0;
      if (o_imem_req && !prev_req) begin
        if (resp_q.size() > 0) begin
          f = resp_q.pop_front();
          wait_left = f.delay;
          word = f.word;
        end else begin
          wait_left = NEVER;
        end
      end
      if (o_imem_req) begin
        if (wait_left == 0) begin
          i_imem_ack  = 1'b1;
          i_imem_data = word;
        end else if (wait_left != NEVER) begin
          wait_left--;
        end
      end else if (late_ack || ($urandom_range(0, 3) == 0)) begin
        i_imem_ack  = 1'b1;
        i_imem_data = 16'($urandom);
      end
      prev_req = o_imem_req;
    end
  end

  initial begin : monitor
    bit  prev_req = 1'b0;
    bit  prev_halt = 1'b0;
    ev_t e;
    int  r;
    forever begin
      @(negedge clk);
      r = cyc - start_cyc;
      if (mon_en) begin
        if (o_imem_req && !prev_req) begin
          if (addr_q.size() == 0) check("unexpected_fetch_addr", int'(o_imem_addr), -1);
          else begin
            e = addr_q.pop_front();
            check("fetch_addr", int'(o_imem_addr), e.a);
            check("fetch_cycle", r, e.cyc);
          end
        end
        if (o_alu_opcode != 4'h0) begin
          if (exec_q.size() == 0) check("unexpected_exec", int'(o_alu_opcode), 0);
          else begin
            e = exec_q.pop_front();
            check("exec_opcode", int'(o_alu_opcode), e.a);
            check("exec_dest", int'(o_alu_destadd), e.b);
            check("exec_rd1", int'(o_rf_rd_add1), e.c);
            check("exec_rd2", int'(o_rf_rd_add2), e.d);
            check("exec_cycle", r, e.cyc);
          end
        end
        if (o_wb_en) begin
          if (wb_q.size() == 0) check("unexpected_wb", int'(o_wb_en), 0);
          else begin
            e = wb_q.pop_front();
            check("wb_add", int'(o_wb_add), e.a);
            check("wb_rd1", int'(o_rf_rd_add1), e.b);
            check("wb_rd2", int'(o_rf_rd_add2), e.c);
            check("wb_cycle", r, e.cyc);
          end
        end
        if (o_halted && !prev_halt) begin
          if (halt_q.size() == 0) check("unexpected_halt", int'(o_halted), 0);
          else begin
            e = halt_q.pop_front();
            check("halt_count", int'(o_instr_count), e.a);
            check("halt_error", int'(o_error), e.b);
            check("halt_busy", int'(o_busy), 0);
            check("halt_cycle", r, e.cyc);
          end
        end
      end
      prev_req  = o_imem_req;
      prev_halt = o_halted;
    end
  end

  task automatic check_quiet(string tag);
    check({tag, "_req"}, int'(o_imem_req), 0);
    check({tag, "_addr"}, int'(o_imem_addr), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_halted"}, int'(o_halted), 0);
    check({tag, "_error"}, int'(o_error), 0);
    check({tag, "_count"}, int'(o_instr_count), 0);
    check({tag, "_alu_opcode"}, int'(o_alu_opcode), 0);
    check({tag, "_wb_en"}, int'(o_wb_en), 0);
  endtask

  task automatic launch();
    resp_q = prog;
    build_expect();
    mon_en = 1'b1;
    @(negedge clk);
    i_start   = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_prog(string tag, int budget);
    bit done = 1'b0;
    launch();
    for (int k = 0; k < budget && !done; k++) begin
      if (o_halted) done = 1'b1;
      else begin
        // Start pulses while busy must be ignored.
        i_start = o_busy && ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
    end
    i_start = 1'b0;
    if (!done) check({tag, "_halt_reached"}, 0, 1);
    @(negedge clk);
    check({tag, "_pending_events"}, addr_q.size() + exec_q.size() + wb_q.size() + halt_q.size(), 0);
    flush();
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] v;
    case ($urandom_range(0, 9))
      0: v = 4'd1;
      1: v = 4'd2;
      2: v = 4'd4;
      3: v = 4'd8;
      4: v = 4'd0;
      default: begin
        v = 4'($urandom);
        while (is_alu(v) || v == 4'hF) v = 4'($urandom);
      end
    endcase
    return v;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(0, 9) == 0) ? FETCH_TIMEOUT : $urandom_range(0, 3);
  endfunction

  initial begin : main
    bit found;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_step  = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("after_reset");

    prog.delete(); add(0, 16'h1312); add(0, 16'h2412); add(0, 16'hF000);
    run_prog("basic", 100);
    prog.delete(); add(3, 16'h1312); add(3, 16'h2412); add(3, 16'hF000);
    run_prog("stall3", 100);
    prog.delete(); add(FETCH_TIMEOUT, 16'h4A31); add(0, 16'h8BC2); add(FETCH_TIMEOUT, 16'hF000);
    run_prog("late_ack_edge", 150);
    prog.delete(); add(NEVER, 16'h0000);
    run_prog("timeout", 100);
    prog.delete(); add(0, 16'h1312); add(0, 16'hF000);
    run_prog("restart_after_error", 100);
    prog.delete();
    for (int i = 0; i < 4; i++) add(i % 2, 16'h0000);
    add(0, 16'h1A5C); add(1, 16'h3000); add(0, 16'hF123);
    run_prog("pc_wrap", 150);

    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(0, 10);
      prog.delete();
      for (int i = 0; i < len; i++) add(rand_delay(), {rand_op(), 12'($urandom)});
      if ($urandom_range(0, 4) == 0) add(NEVER, 16'h0000);
      else add(rand_delay(), {4'hF, 12'($urandom)});
      run_prog("random", 600);
    end

    prog.delete(); add(0, 16'h1312); add(2, 16'h2412); add(0, 16'hF000);
    launch();
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (o_alu_opcode != 4'h0) found = 1'b1;
      else @(negedge clk);
    end
    check("reset_reached_exec", int'(found), 1);
    mon_en  = 1'b0;
    i_reset = 1'b1;
    #1;
    check("reset_exec_alu_opcode", int'(o_alu_opcode), 0);
    check("reset_exec_busy", int'(o_busy), 0);
    check("reset_exec_wb_en", int'(o_wb_en), 0);
    flush();
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("late_ack_after_reset");
    late_ack = 1'b0;
    prog.delete(); add(1, 16'h2412); add(0, 16'hF000);
    run_prog("recover", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
